// File: rtl/sitcpxg_tx_ch_mux_if.sv
// Channel-side streams and SiTCP TX-side signals of the N-channel merger.
// The master modport is the merger; the slave modport is its environment.
interface sitcpxg_tx_ch_mux_if #(
    parameter int unsigned N_CH = 4
);
    logic                 USER_SESSION_ESTABLISHED;
    logic                 USER_TX_AFULL;
    logic [64*N_CH-1:0]   CH_D;
    logic [4*N_CH-1:0]    CH_B;
    logic [N_CH-1:0]      CH_LAST;
    logic [N_CH-1:0]      CH_VALID;
    logic [N_CH-1:0]      CH_READY;
    logic [63:0]          USER_TX_D;
    logic [3:0]           USER_TX_B;
    logic [3:0]           CUR_CH;

    modport master (
        input  USER_SESSION_ESTABLISHED, USER_TX_AFULL, CH_D, CH_B, CH_LAST, CH_VALID,
        output CH_READY, USER_TX_D, USER_TX_B, CUR_CH
    );

    modport slave (
        output USER_SESSION_ESTABLISHED, USER_TX_AFULL, CH_D, CH_B, CH_LAST, CH_VALID,
        input  CH_READY, USER_TX_D, USER_TX_B, CUR_CH
    );
endinterface

// File: rtl/sitcpxg_tx_ch_mux.sv
// Round-robin merger of N 64-bit user streams onto the SiTCPXG TX port.
// Every burst is prefixed by a header carrying channel, sequence number and start-of-frame.
module sitcpxg_tx_ch_mux #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned MAX_BURST = 256,
    parameter logic [15:0] HDR_MAGIC = 16'hA55A
) (
    input  logic                 XGMII_CLOCK,
    input  logic                 RSTs,
    sitcpxg_tx_ch_mux_if.master  bus
);
    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [CW-1:0]   cur, cur_nxt;
    logic [CW-1:0]   ptr, ptr_nxt;
    logic [BW-1:0]   bcnt, bcnt_nxt;
    logic [7:0]      seq     [N_CH];
    logic [7:0]      seq_nxt [N_CH];
    logic [N_CH-1:0] mid, mid_nxt;
    logic [63:0]     tx_d, tx_d_nxt;
    logic [3:0]      tx_b, tx_b_nxt;

    logic [63:0]     ch_d [N_CH];
    logic [3:0]      ch_b [N_CH];
    logic [3:0]      cur_b;
    logic            go;
    logic            accept;
    logic            found;
    logic [CW-1:0]   pick;
    logic [CW-1:0]   idx;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ch_d[k] = bus.CH_D[64*k +: 64];
            ch_b[k] = bus.CH_B[4*k +: 4];
        end
    end

    assign go     = bus.USER_SESSION_ESTABLISHED & ~bus.USER_TX_AFULL;
    assign accept = (state == S_DATA) & go & bus.CH_VALID[cur];
    assign cur_b  = (ch_b[cur] > 4'd8) ? 4'd8 : ch_b[cur];

    // First requester at or after ptr, wrapping; ptr is one past the last grant.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = CW'((32'(ptr) + 32'(i)) % N_CH);
            if (!found && bus.CH_VALID[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // READY follows go directly so backpressure stops transfers in the same cycle.
    always_comb begin
        bus.CH_READY = '0;
        if (state == S_DATA && go) begin
            bus.CH_READY[cur] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        ptr_nxt   = ptr;
        bcnt_nxt  = bcnt;
        seq_nxt   = seq;
        mid_nxt   = mid;
        tx_d_nxt  = tx_d;
        tx_b_nxt  = 4'd0;
        if (!bus.USER_SESSION_ESTABLISHED) begin
            // A closed session forgets all framing so the host restarts cleanly.
            state_nxt = S_IDLE;
            mid_nxt   = '0;
            for (int k = 0; k < N_CH; k++) begin
                seq_nxt[k] = 8'd0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        cur_nxt   = pick;
                        ptr_nxt   = CW'((32'(pick) + 32'd1) % N_CH);
                        state_nxt = S_HDR;
                    end
                end
                S_HDR: begin
                    if (go) begin
                        tx_d_nxt     = {HDR_MAGIC, 4'b0, 4'(cur), seq[cur], ~mid[cur], 31'b0};
                        tx_b_nxt     = 4'd8;
                        seq_nxt[cur] = seq[cur] + 8'd1;
                        bcnt_nxt     = '0;
                        state_nxt    = S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        tx_d_nxt = ch_d[cur];
                        tx_b_nxt = cur_b;
                        bcnt_nxt = bcnt + 1'b1;
                        if (bus.CH_LAST[cur]) begin
                            mid_nxt[cur] = 1'b0;
                            state_nxt    = S_IDLE;
                        end else if (bcnt == BURST_END) begin
                            mid_nxt[cur] = 1'b1;
                            state_nxt    = S_IDLE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge XGMII_CLOCK or posedge RSTs) begin
        if (RSTs) begin
            state <= S_IDLE;
            cur   <= '0;
            ptr   <= '0;
            bcnt  <= '0;
            mid   <= '0;
            tx_d  <= '0;
            tx_b  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                seq[k] <= 8'd0;
            end
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            ptr   <= ptr_nxt;
            bcnt  <= bcnt_nxt;
            mid   <= mid_nxt;
            tx_d  <= tx_d_nxt;
            tx_b  <= tx_b_nxt;
            seq   <= seq_nxt;
        end
    end

    assign bus.USER_TX_D = tx_d;
    assign bus.USER_TX_B = tx_b;
    assign bus.CUR_CH    = 4'(cur);
endmodule

// File: tb/tb_sitcpxg_tx_ch_mux.sv
// Randomised bench for sitcpxg_tx_ch_mux: a frame-level round-robin model fills an
// expected queue, a monitor pops and compares every written word.
module tb_sitcpxg_tx_ch_mux;
    localparam int unsigned N_CH      = 4;
    localparam int unsigned MAX_BURST = 4;
    localparam logic [15:0] MAGIC     = 16'hA55A;

    typedef struct packed { logic [63:0] d; logic [3:0] b; logic last; } word_t;
    typedef struct packed { logic [63:0] d; logic [3:0] b; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sitcpxg_tx_ch_mux_if #(.N_CH(N_CH)) bus ();

    sitcpxg_tx_ch_mux #(.N_CH(N_CH), .MAX_BURST(MAX_BURST), .HDR_MAGIC(MAGIC)) dut (
        .XGMII_CLOCK (clk),
        .RSTs        (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    word_t drv_q [N_CH][$];
    word_t mdl_q [N_CH][$];
    exp_t  exp_q [$];
    int    offered_total = 0;
    int    acc_total = 0;
    int    acc_ch0 = 0;
    bit    sess_req = 1'b1;
    int    afull_pct = 0;
    bit    mon_en = 1'b1;

    // Reference model state: frame-level round robin over whole queues.
    int         m_ptr;
    int         m_cur;
    int         m_cnt;
    bit         m_busy;
    logic [7:0] m_seq [N_CH];
    bit         m_mid [N_CH];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_cur = 0; m_cnt = 0; m_busy = 1'b0;
        for (int c = 0; c < N_CH; c++) begin m_seq[c] = 8'd0; m_mid[c] = 1'b0; end
    endfunction

    function automatic void model_drop();
        m_busy = 1'b0;
        for (int c = 0; c < N_CH; c++) begin m_seq[c] = 8'd0; m_mid[c] = 1'b0; end
    endfunction

    function automatic void offer(input int c, input logic [63:0] d, input logic [3:0] b, input bit last);
        word_t w;
        w.d = d; w.b = b; w.last = last;
        drv_q[c].push_back(w);
        mdl_q[c].push_back(w);
        offered_total++;
    endfunction

    // Expand every pending word into the header/data stream the host should see.
    function automatic void model_run();
        bit    more = 1'b1;
        bit    found;
        int    sel;
        int    c;
        word_t w;
        exp_t  e;
        while (more) begin
            if (!m_busy) begin
                found = 1'b0; sel = 0;
                for (int i = 0; i < N_CH; i++) begin
                    c = (m_ptr + i) % N_CH;
                    if (!found && mdl_q[c].size() > 0) begin found = 1'b1; sel = c; end
                end
                if (!found) begin
                    more = 1'b0;
                end else begin
                    m_cur = sel; m_ptr = (sel + 1) % N_CH; m_busy = 1'b1; m_cnt = 0;
                    e.d = {MAGIC, 4'b0, 4'(sel), m_seq[sel], ~m_mid[sel], 31'b0};
                    e.b = 4'd8;
                    exp_q.push_back(e);
                    m_seq[sel] = m_seq[sel] + 8'd1;
                end
            end
            if (more) begin
                if (mdl_q[m_cur].size() == 0) begin
                    more = 1'b0;
                end else begin
                    w = mdl_q[m_cur].pop_front();
                    e.d = w.d;
                    e.b = (w.b > 4'd8) ? 4'd8 : w.b;
                    exp_q.push_back(e);
                    m_cnt++;
                    if (w.last) begin
                        m_mid[m_cur] = 1'b0; m_busy = 1'b0;
                    end else if (m_cnt == MAX_BURST) begin
                        m_mid[m_cur] = 1'b1; m_busy = 1'b0;
                    end
                end
            end
        end
    endfunction

    function automatic int drv_pending();
        int s = 0;
        for (int c = 0; c < N_CH; c++) s += drv_q[c].size();
        return s;
    endfunction

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || drv_pending() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("pending_after_drain", 64'(exp_q.size() + drv_pending()), 64'd0);
        repeat (3) @(negedge clk);
        #2;
    endtask

    // Source driver: retire accepted words, present the next head of each channel queue.
    initial begin : driver
        logic [N_CH-1:0] acc;
        bus.USER_SESSION_ESTABLISHED = 1'b0;
        bus.USER_TX_AFULL = 1'b0;
        bus.CH_D = '0; bus.CH_B = '0; bus.CH_LAST = '0; bus.CH_VALID = '0;
        forever begin
            @(negedge clk);
            acc = bus.CH_VALID & bus.CH_READY;
            @(posedge clk);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (acc[c] && drv_q[c].size() > 0) begin
                    void'(drv_q[c].pop_front());
                    acc_total++;
                    if (c == 0) acc_ch0++;
                end
                if (drv_q[c].size() > 0) begin
                    bus.CH_VALID[c]        = 1'b1;
                    bus.CH_D[64*c +: 64]   = drv_q[c][0].d;
                    bus.CH_B[4*c +: 4]     = drv_q[c][0].b;
                    bus.CH_LAST[c]         = drv_q[c][0].last;
                end else begin
                    bus.CH_VALID[c] = 1'b0;
                    bus.CH_LAST[c]  = 1'b0;
                end
            end
            bus.USER_SESSION_ESTABLISHED = sess_req;
            bus.USER_TX_AFULL = (int'($urandom_range(0, 99)) < afull_pct);
        end
    end

    initial begin : monitor
        bit   prev_go = 1'b0;
        bit   go;
        exp_t e;
        forever begin
            @(negedge clk);
            go = bus.USER_SESSION_ESTABLISHED && !bus.USER_TX_AFULL;
            if (mon_en && !rst) begin
                if (!prev_go) check("b_zero_after_stall", 64'(bus.USER_TX_B), 64'd0);
                if (bus.CH_READY != '0)
                    check("ready_onehot_with_go", {63'd0, ($onehot(bus.CH_READY) && go)}, 64'd1);
                if (bus.USER_TX_B != 4'd0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word_b", 64'(bus.USER_TX_B), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_d", bus.USER_TX_D, e.d);
                        check("tx_b", 64'(bus.USER_TX_B), 64'(e.b));
                    end
                end
            end
            prev_go = go;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int nf;
        int len;
        int t;
        model_reset();
        sess_req = 1'b1;
        afull_pct = 0;
        repeat (3) @(negedge clk);
        check("rst_tx_d", bus.USER_TX_D, 64'd0);
        check("rst_tx_b", 64'(bus.USER_TX_B), 64'd0);
        check("rst_cur_ch", 64'(bus.CUR_CH), 64'd0);
        check("rst_ready", 64'(bus.CH_READY), 64'd0);
        #2 rst = 1'b0;
        @(negedge clk); #2;

        // Single three-word frame on channel 0, last word partial.
        offer(0, 64'h0011_2233_4455_6677, 4'd8, 1'b0);
        offer(0, 64'h8899_AABB_CCDD_EEFF, 4'd8, 1'b0);
        offer(0, 64'h0123_4567_89AB_CDEF, 4'd5, 1'b1);
        model_run();
        wait_drain(200);
        check("ch0_accepted", 64'(acc_ch0), 64'd3);

        // Random multi-channel rounds with random backpressure and B clamping.
        for (int r = 0; r < 8; r++) begin
            afull_pct = int'($urandom_range(0, 40));
            for (int c = 0; c < N_CH; c++) begin
                nf = int'($urandom_range(0, 2));
                for (int f = 0; f < nf; f++) begin
                    len = int'($urandom_range(1, 10));
                    for (int w = 0; w < len; w++)
                        offer(c, {$urandom, $urandom}, 4'($urandom_range(1, 15)), w == len - 1);
                end
            end
            model_run();
            wait_drain(3000);
            check("accepted_vs_offered", 64'(acc_total), 64'(offered_total));
        end

        // Long channel-2 frame alongside channel 0, forcing preemption.
        afull_pct = 0;
        for (int w = 0; w < 10; w++) offer(2, {$urandom, $urandom}, 4'd8, w == 9);
        for (int w = 0; w < 3; w++) offer(0, {$urandom, $urandom}, 4'd7, w == 2);
        model_run();
        wait_drain(400);

        // Five-cycle AFULL in the middle of a burst.
        for (int w = 0; w < 6; w++) offer(2, {$urandom, $urandom}, 4'd8, w == 5);
        model_run();
        t = 0;
        while (exp_q.size() > 6 && t < 100) begin @(negedge clk); t++; end
        #2 afull_pct = 100;
        repeat (5) begin
            @(negedge clk);
            check("ready_during_afull", 64'(bus.CH_READY), 64'd0);
        end
        #2 afull_pct = 0;
        wait_drain(200);
        check("accepted_after_afull", 64'(acc_total), 64'(offered_total));

        // Session drop while channel 1 waits mid-frame after a forced switch.
        for (int w = 0; w < 5; w++) offer(1, {$urandom, $urandom}, 4'd8, 1'b0);
        model_run();
        wait_drain(200);
        sess_req = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        model_drop();
        offer(1, {$urandom, $urandom}, 4'd6, 1'b1);
        model_run();
        repeat (4) begin
            @(negedge clk);
            check("ready_session_closed", 64'(bus.CH_READY), 64'd0);
        end
        #2 sess_req = 1'b1;
        wait_drain(200);

        // Asynchronous reset right after a header goes out on channel 3.
        mon_en = 1'b0;
        for (int w = 0; w < 4; w++) begin
            word_t rw;
            rw.d = {$urandom, $urandom}; rw.b = 4'd8; rw.last = (w == 3);
            drv_q[3].push_back(rw);
        end
        t = 0;
        while (!(bus.USER_TX_B == 4'd8 && bus.USER_TX_D[63:48] == MAGIC) && t < 50) begin
            @(negedge clk); t++;
        end
        check("hdr_before_reset", 64'(bus.CUR_CH), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx_d", bus.USER_TX_D, 64'd0);
        check("async_rst_tx_b", 64'(bus.USER_TX_B), 64'd0);
        check("async_rst_cur_ch", 64'(bus.CUR_CH), 64'd0);
        check("async_rst_ready", 64'(bus.CH_READY), 64'd0);
        for (int c = 0; c < N_CH; c++) begin drv_q[c].delete(); mdl_q[c].delete(); end
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        offered_total = 0;
        acc_total = 0;
        #2 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk); #2;

        // After reset, channel 0 wins over channel 2 when both request.
        for (int w = 0; w < 2; w++) offer(2, {$urandom, $urandom}, 4'd8, w == 1);
        for (int w = 0; w < 2; w++) offer(0, {$urandom, $urandom}, 4'd3, w == 1);
        model_run();
        wait_drain(200);
        check("accepted_after_reset", 64'(acc_total), 64'(offered_total));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sitcpxg_tx_ch_mux.md
Name: sitcpxg_tx_ch_mux

Overview:
N-channel round-robin merger that feeds the 10GbE SiTCP TCP transmit interface (USER_TX_D/USER_TX_B) from several independent 64-bit user streams.
Each burst is preceded by a header word carrying channel ID, a per-channel sequence number and a start-of-frame flag, so the host can demultiplex the TCP byte stream.
It honours USER_TX_AFULL backpressure and gates all traffic on USER_SESSION_ESTABLISHED.
It sits between user data sources and the SiTCPXG core in the XGMII_CLOCK domain.

Parameters:
N_CH, 4, number of input channels (1..16)
MAX_BURST, 256, maximum data words per grant before a forced channel switch (1..65535)
HDR_MAGIC, 16'hA55A, value placed in header bits [63:48]

Ports:
XGMII_CLOCK  in  1  clock, the 156.25 MHz XGMII domain
RSTs  in  1  reset, asynchronous assert, active-high
USER_SESSION_ESTABLISHED  in  1  TCP session open, from SiTCP
USER_TX_AFULL  in  1  SiTCP TX almost full
CH_D  in  64*N_CH  channel data; channel k occupies [64k+63:64k]
CH_B  in  4*N_CH  valid byte count per word (0..8, values >8 clamp to 8)
CH_LAST  in  N_CH  word is last of a user frame
CH_VALID  in  N_CH  word valid
CH_READY  out  N_CH  word accepted when VALID&READY
USER_TX_D  out  64  data to SiTCP
USER_TX_B  out  4  byte count to SiTCP; 0 means no write
CUR_CH  out  4  currently granted channel, for debug

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, RR pointer 0, all sequence counters 0, all mid-frame flags 0.
- Define go = USER_SESSION_ESTABLISHED & ~USER_TX_AFULL, sampled in the same cycle.
- FSM IDLE:
  - If any CH_VALID is high, grant the first requesting channel searching from (last_grant+1) mod N_CH. After reset the search starts at channel 0.
  - Latch the grant into CUR_CH and go to HDR.
- FSM HDR:
  - When go=1, register one header word, then go to DATA.
  - Header word: USER_TX_D = {HDR_MAGIC, 4'b0, CUR_CH, seq[CUR_CH] (8b), START, 31'b0}, with USER_TX_B = 8.
  - START = ~midframe[CUR_CH].
  - seq[CUR_CH] increments modulo 256 after the header is emitted.
  - When go=0, hold in HDR and output B = 0.
- FSM DATA:
  - CH_READY[CUR_CH] = go. All other READY bits are 0. READY is combinational from go and state.
  - On each accepted word: USER_TX_D <= CH_D of CUR_CH and USER_TX_B <= clamp(CH_B). Latency is 1 cycle. A word with B = 0 is consumed and emitted as B = 0.
  - Burst counter increments on each accepted word.
  - Accepted word with LAST=1: clear midframe[CUR_CH], go to IDLE.
  - Else, if burst count reaches MAX_BURST: set midframe[CUR_CH], go to IDLE. The channel loses priority; the next header for this channel has START=0.
  - A cycle with no accepted word drives USER_TX_B = 0.
- IDLE arbitration costs 1 cycle. Header costs 1 cycle. Minimum overhead is 2 cycles per burst.
- Session drop (USER_SESSION_ESTABLISHED falls) in any state:
  - FSM goes to IDLE the next cycle.
  - Clear all midframe flags and all seq counters.
  - CH_READY is 0 while the session is closed. Input words are held, not dropped.
- AFULL mid-burst: READY drops the same cycle. The grant, burst count and FSM state are retained, and transfer resumes when AFULL clears.
- Reset while mid-burst: immediate return to reset state. A partially transferred frame is abandoned; the host resynchronises on the next START=1 header.
- N_CH = 1: arbitration always picks channel 0.
- MAX_BURST = 1: header before every word.

Test Plan:
1. N_CH=4, session up, ch0 sends 3 words (B=8,8,5, LAST on 3rd) -> USER_TX output sequence: header {A55A,ch0,seq0,START=1} B=8, then D0 B=8, D1 B=8, D2 B=5. CH_READY[0] is high for 3 accepted cycles.
2. ch1 and ch3 valid simultaneously after last grant ch0 -> ch1 is served first, then ch3. Each header carries seq=0. On the next ch1 frame, header seq=1.
3. MAX_BURST=4, ch2 streams 10 words with LAST on the 10th while ch0 waits -> output order: ch2 hdr START=1 + 4 words, ch0 burst, ch2 hdr START=0 + 4 words, …, last ch2 burst of 2 words.
4. Assert USER_TX_AFULL for 5 cycles mid-burst -> CH_READY falls the same cycle, USER_TX_B=0 for those cycles, no word lost or duplicated, data resumes in order.
5. Drop USER_SESSION_ESTABLISHED mid-frame, then re-establish -> READY=0 while closed, FSM IDLE, the next header shows seq=0 and START=1.
6. Assert RSTs asynchronously mid-header -> all outputs 0 immediately, without waiting for a clock edge. After release, the first grant is channel 0 when it requests.
